// File: rtl/lbp_pkg.sv
// lbp_pkg: shared types and constants for the LBP histogram block.
// Holds the FSM state enum, image geometry constants and the border check
// used to flag codes arriving on the outermost pixel ring.
package lbp_pkg;

  typedef enum logic [1:0] {
    ACCUM = 2'd0,
    DUMP  = 2'd1,
    DONE  = 2'd2
  } state_e;

  localparam int IMG_W      = 128;
  localparam int BORDER_MAX = IMG_W - 1;
  localparam int BINS       = 256;

  // Address layout is {row[13:7], col[6:0]}; a border pixel has no full
  // 3x3 neighbourhood, so a code for it indicates an upstream fault.
  function automatic logic is_border(input logic [13:0] addr);
    logic [6:0] row;
    logic [6:0] col;
    row = addr[13:7];
    col = addr[6:0];
    return (row == 7'd0) || (row == 7'(BORDER_MAX)) ||
           (col == 7'd0) || (col == 7'(BORDER_MAX));
  endfunction

endpackage

// File: rtl/lbp_hist_if.sv
// lbp_hist_if: bundles the LBP code input stream, control strobes and the
// histogram output stream of lbp_hist.
// master: the producer/consumer side (drives codes, finish, clear, ready).
// slave:  the histogram block itself.
interface lbp_hist_if #(
  parameter int CODE_W = 8,
  parameter int ADDR_W = 14,
  parameter int CNT_W  = 14
);
  logic              lbp_valid;
  logic [ADDR_W-1:0] lbp_addr;
  logic [CODE_W-1:0] lbp_data;
  logic              finish;
  logic              clear;
  logic              hist_valid;
  logic              hist_ready;
  logic [CODE_W-1:0] hist_bin;
  logic [CNT_W-1:0]  hist_count;
  logic              hist_last;
  logic              hist_done;
  logic [CNT_W-1:0]  pix_cnt;
  logic              addr_err;

  modport master (
    output lbp_valid, lbp_addr, lbp_data, finish, clear, hist_ready,
    input  hist_valid, hist_bin, hist_count, hist_last, hist_done,
           pix_cnt, addr_err
  );

  modport slave (
    input  lbp_valid, lbp_addr, lbp_data, finish, clear, hist_ready,
    output hist_valid, hist_bin, hist_count, hist_last, hist_done,
           pix_cnt, addr_err
  );
endinterface

// File: rtl/lbp_hist_bank.sv
// lbp_hist_bank: 2**CODE_W x CNT_W counter array, one saturating increment
// port, one combinational read port, synchronous clear (wins over increment).
// Ports: clk, rst_n, clr_i, inc_i/inc_idx_i, rd_idx_i -> rd_cnt_o.
// An increment becomes visible on the read port the cycle after it is applied.
module lbp_hist_bank #(
  parameter int CODE_W = 8,
  parameter int CNT_W  = 14
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr_i,
  input  logic              inc_i,
  input  logic [CODE_W-1:0] inc_idx_i,
  input  logic [CODE_W-1:0] rd_idx_i,
  output logic [CNT_W-1:0]  rd_cnt_o
);

  localparam int N = 1 << CODE_W;

  logic [CNT_W-1:0] bin_q [N];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N; i++) bin_q[i] <= '0;
    end else if (clr_i) begin
      for (int i = 0; i < N; i++) bin_q[i] <= '0;
    end else if (inc_i && (bin_q[inc_idx_i] != '1)) begin
      bin_q[inc_idx_i] <= bin_q[inc_idx_i] + 1'b1;
    end
  end

  assign rd_cnt_o = bin_q[rd_idx_i];

endmodule

// File: rtl/lbp_hist.sv
// lbp_hist: accumulates a histogram of LBP codes for one image, then streams
// it out one bin per accepted handshake and parks in DONE until cleared.
// Ports: clk, reset (async, active-low), io (lbp_hist_if.slave).
// Latency: entry cycle after the finish rising edge, then 1 bin/cycle while
// hist_ready is high; with hist_ready low all histogram outputs hold.
module lbp_hist
  import lbp_pkg::*;
#(
  parameter int CODE_W = 8,
  parameter int ADDR_W = 14,
  parameter int CNT_W  = 14
) (
  input  logic       clk,
  input  logic       reset,
  lbp_hist_if.slave  io
);

  state_e            state_q, state_d;
  logic              fin_q;
  logic [CODE_W-1:0] bin_q, bin_d;
  logic [CNT_W-1:0]  pix_q, pix_d;
  logic              err_q, err_d;
  logic [CNT_W-1:0]  rd_cnt;
  logic              fin_rise;
  logic              accept;
  logic              hs;

  // A finish level held high never retriggers; only a 0->1 transition counts.
  assign fin_rise = io.finish & ~fin_q;
  // Clear wins over a same-cycle sample.
  assign accept   = (state_q == ACCUM) && io.lbp_valid && !io.clear;
  assign hs       = io.hist_valid && io.hist_ready;

  lbp_hist_bank #(
    .CODE_W (CODE_W),
    .CNT_W  (CNT_W)
  ) u_bank (
    .clk       (clk),
    .rst_n     (reset),
    .clr_i     (io.clear),
    .inc_i     (accept),
    .inc_idx_i (io.lbp_data),
    .rd_idx_i  (bin_q),
    .rd_cnt_o  (rd_cnt)
  );

  always_comb begin
    state_d = state_q;
    bin_d   = bin_q;
    pix_d   = pix_q;
    err_d   = err_q;
    if (io.clear) begin
      state_d = ACCUM;
      bin_d   = '0;
      pix_d   = '0;
      err_d   = 1'b0;
    end else begin
      unique case (state_q)
        ACCUM: begin
          if (io.lbp_valid) begin
            if (pix_q != '1) pix_d = pix_q + 1'b1;
            if (is_border(14'(io.lbp_addr))) err_d = 1'b1;
          end
          if (fin_rise) begin
            state_d = DUMP;
            bin_d   = '0;
          end
        end
        DUMP: begin
          if (hs) begin
            if (bin_q == '1) state_d = DONE;
            else             bin_d   = bin_q + 1'b1;
          end
        end
        DONE: begin
          state_d = DONE;
        end
        default: begin
          state_d = ACCUM;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ACCUM;
      fin_q   <= 1'b0;
      bin_q   <= '0;
      pix_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      fin_q   <= io.finish;
      bin_q   <= bin_d;
      pix_q   <= pix_d;
      err_q   <= err_d;
    end
  end

  // Stream outputs decode straight from state so an async reset drops them
  // immediately; the bank is frozen outside ACCUM, so hist_count is stable
  // while a bin is stalled.
  assign io.hist_valid = (state_q == DUMP);
  assign io.hist_bin   = bin_q;
  assign io.hist_count = rd_cnt;
  assign io.hist_last  = (state_q == DUMP) && (bin_q == '1);
  assign io.hist_done  = (state_q == DONE);
  assign io.pix_cnt    = pix_q;
  assign io.addr_err   = err_q;

endmodule

// File: tb/tb_lbp_hist.sv
// tb_lbp_hist: randomized and directed stimulus for lbp_hist, checked against
// a per-bin count array updated from the histogram rules.
module tb_lbp_hist;

  localparam int CODE_W = 8;
  localparam int ADDR_W = 14;
  localparam int CNT_W  = 14;
  localparam int SAT    = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  lbp_hist_if #(.CODE_W(CODE_W), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) bus ();

  lbp_hist #(.CODE_W(CODE_W), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .reset (reset),
    .io    (bus)
  );

  int checks = 0;
  int errors = 0;

  int exp_bin [256];
  int exp_pix;
  bit exp_err;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 256; i++) exp_bin[i] = 0;
    exp_pix = 0;
    exp_err = 1'b0;
  endtask

  // Present one code this cycle (state assumed ACCUM) and update the model.
  task automatic put_code(input logic [7:0] code, input logic [6:0] row, input logic [6:0] col);
    bus.lbp_valid = 1'b1;
    bus.lbp_data  = code;
    bus.lbp_addr  = {row, col};
    if (exp_bin[code] < SAT) exp_bin[code]++;
    if (exp_pix < SAT) exp_pix++;
    if (row == 7'd0 || row == 7'd127 || col == 7'd0 || col == 7'd127) exp_err = 1'b1;
  endtask

  task automatic drive_code(input logic [7:0] code, input logic [6:0] row, input logic [6:0] col);
    put_code(code, row, col);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    bus.lbp_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic do_clear();
    bus.lbp_valid = 1'b0;
    bus.clear = 1'b1;
    @(negedge clk);
    bus.clear = 1'b0;
    model_clear();
  endtask

  // Raise finish (optionally with a same-cycle code) and consume the dump.
  // mode 0: ready tied high, 1: ready pattern 1-0-0-1, 2: random ready.
  task automatic run_dump(input int mode, input bit with_code, input logic [7:0] code);
    int edges;
    int idx;
    int hs;
    bit done_seen;
    bit rdy;
    edges = 0; idx = 0; hs = 0; done_seen = 1'b0;
    bus.finish = 1'b1;
    bus.hist_ready = (mode == 0);
    if (with_code) put_code(code, 7'd20, 7'd30);
    else bus.lbp_valid = 1'b0;
    while (edges < 4000) begin
      @(negedge clk);
      edges++;
      bus.lbp_valid = 1'b0;
      if (bus.hist_done) begin
        done_seen = 1'b1;
        break;
      end
      if (!bus.hist_valid) begin
        check("valid_in_dump", 32'(bus.hist_valid), 32'd1);
        break;
      end
      check("dump_bin", 32'(bus.hist_bin), 32'(idx));
      check("dump_count", 32'(bus.hist_count), 32'(exp_bin[idx]));
      check("dump_last", 32'(bus.hist_last), 32'(idx == 255));
      case (mode)
        0:       rdy = 1'b1;
        1:       rdy = ((edges - 1) % 4 == 0) || ((edges - 1) % 4 == 3);
        default: rdy = 1'($urandom % 2);
      endcase
      bus.hist_ready = rdy;
      if (rdy) begin
        idx++;
        hs++;
      end
    end
    check("dump_done", 32'(done_seen), 32'd1);
    check("handshakes", 32'(hs), 32'd256);
    if (mode == 0) check("dump_latency", 32'(edges), 32'd257);
    check("valid_after_done", 32'(bus.hist_valid), 32'd0);
    check("last_after_done", 32'(bus.hist_last), 32'd0);
  endtask

  initial begin
    int n;
    logic [7:0] c;
    logic [6:0] r;
    bus.lbp_valid  = 1'b0;
    bus.lbp_addr   = '0;
    bus.lbp_data   = '0;
    bus.finish     = 1'b0;
    bus.clear      = 1'b0;
    bus.hist_ready = 1'b0;
    model_clear();
    reset = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_valid", 32'(bus.hist_valid), 32'd0);
    check("rst_done", 32'(bus.hist_done), 32'd0);
    check("rst_last", 32'(bus.hist_last), 32'd0);
    check("rst_bin", 32'(bus.hist_bin), 32'd0);
    check("rst_pix", 32'(bus.pix_cnt), 32'd0);
    check("rst_err", 32'(bus.addr_err), 32'd0);
    reset = 1'b1;
    @(negedge clk);

    // Full interior raster.
    for (int row = 0; row < 126; row++)
      for (int col = 0; col < 126; col++)
        drive_code(8'((row * 126 + col) % 256), 7'(row + 1), 7'(col + 1));
    idle(1);
    check("raster_pix", 32'(bus.pix_cnt), 32'd15876);
    check("raster_err", 32'(bus.addr_err), 32'd0);
    run_dump(0, 1'b0, 8'h00);
    bus.finish = 1'b0;

    // Three back-to-back identical codes, ready tied high.
    do_clear();
    check("clr_pix", 32'(bus.pix_cnt), 32'd0);
    check("clr_done", 32'(bus.hist_done), 32'd0);
    for (int i = 0; i < 3; i++) drive_code(8'hA5, 7'd10, 7'd10);
    idle(1);
    check("a5_pix", 32'(bus.pix_cnt), 32'd3);
    run_dump(0, 1'b0, 8'h00);
    bus.finish = 1'b0;

    // Random codes with gaps and occasional border addresses, ready 1-0-0-1.
    do_clear();
    for (int i = 0; i < 400; i++) begin
      if ($urandom % 4 != 0) begin
        c = ($urandom % 3 == 0) ? 8'($urandom) : 8'($urandom_range(0, 3) * 17);
        r = ($urandom % 16 == 0) ? 7'd127 : 7'($urandom_range(1, 126));
        drive_code(c, r, 7'($urandom_range(1, 126)));
      end else begin
        idle(1);
      end
    end
    idle(1);
    check("rand_pix", 32'(bus.pix_cnt), 32'(exp_pix));
    check("rand_err", 32'(bus.addr_err), 32'(exp_err));
    run_dump(1, 1'b0, 8'h00);
    bus.finish = 1'b0;

    // Border address sets a sticky error; random ready during the dump.
    do_clear();
    drive_code(8'h01, 7'd0, 7'd5);
    idle(1);
    check("border_err", 32'(bus.addr_err), 32'd1);
    for (int i = 0; i < 5; i++) drive_code(8'($urandom), 7'd50, 7'd60);
    idle(2);
    check("border_sticky", 32'(bus.addr_err), 32'd1);
    run_dump(2, 1'b0, 8'h00);
    check("border_sticky_done", 32'(bus.addr_err), 32'd1);
    bus.finish = 1'b0;
    do_clear();
    check("border_cleared", 32'(bus.addr_err), 32'd0);

    // Code in the same cycle as the finish rising edge, then finish retriggers.
    for (int i = 0; i < 8; i++) drive_code(8'($urandom), 7'd64, 7'd64);
    idle(1);
    run_dump(0, 1'b1, 8'h10);
    bus.finish = 1'b0;
    idle(2);
    bus.finish = 1'b1;
    idle(3);
    check("refinish_done", 32'(bus.hist_done), 32'd1);
    check("refinish_valid", 32'(bus.hist_valid), 32'd0);
    do_clear();
    idle(5);
    check("held_finish_done", 32'(bus.hist_done), 32'd0);
    check("held_finish_valid", 32'(bus.hist_valid), 32'd0);
    drive_code(8'h33, 7'd3, 7'd3);
    idle(1);
    check("held_finish_pix", 32'(bus.pix_cnt), 32'd1);
    bus.finish = 1'b0;

    // Clear aborts a dump at bin 40.
    do_clear();
    for (int i = 0; i < 20; i++) drive_code(8'($urandom_range(30, 50)), 7'd9, 7'd9);
    idle(1);
    bus.finish = 1'b1;
    bus.hist_ready = 1'b1;
    n = 0;
    while (n < 500 && !(bus.hist_valid && bus.hist_bin == 8'd40)) begin
      @(negedge clk);
      n++;
    end
    check("reach_bin40", 32'(bus.hist_valid && bus.hist_bin == 8'd40), 32'd1);
    do_clear();
    check("abort_valid", 32'(bus.hist_valid), 32'd0);
    check("abort_last", 32'(bus.hist_last), 32'd0);
    check("abort_bin", 32'(bus.hist_bin), 32'd0);
    check("abort_done", 32'(bus.hist_done), 32'd0);
    check("abort_pix", 32'(bus.pix_cnt), 32'd0);
    bus.finish = 1'b0;
    idle(2);
    run_dump(2, 1'b0, 8'h00);
    bus.finish = 1'b0;

    // Async reset mid-accumulation.
    do_clear();
    for (int i = 0; i < 10; i++) drive_code(8'($urandom), 7'd70, 7'd70);
    #2;
    reset = 1'b0;
    #1;
    check("async_pix", 32'(bus.pix_cnt), 32'd0);
    check("async_valid", 32'(bus.hist_valid), 32'd0);
    bus.lbp_valid = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    model_clear();
    @(negedge clk);
    check("post_reset_pix", 32'(bus.pix_cnt), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
